traffic_light_ctrl: RTL and testbench

- Parametrised two-road (main highway / country lane) traffic light controller. Successor to the fixed-timing controller.
- All phase durations are parameters, counted in ticks of an external 1 Hz enable rather than raw clocks.
- Adds:
  - main-green minimum hold;
  - sensor-driven early termination of country green;
  - registered 2-digit BCD countdown for the existing 7-seg scanner;
  - phase-change strobe.

---
 rtl/traffic_light_ctrl.sv | 175 +++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-road traffic light controller with tick-based phase timing, sensor-driven
// country green, BCD countdown and phase-change strobe. Optional NIGHT_MODE_EN adds flashing mode.
module traffic_light_ctrl #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned T_MG_MIN = 25,
  parameter int unsigned T_MY     = 5,
  parameter int unsigned T_CG_MIN = 3,
  parameter int unsigned T_CG_MAX = 16,
  parameter int unsigned T_CY     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       car,
  output logic [2:0] m_lt,
  output logic [2:0] c_lt,
  output logic [7:0] remain_bcd,
  output logic       phase_chg
`ifdef NIGHT_MODE_EN
  ,
  input  logic       night
`endif
);

`ifdef NIGHT_MODE_EN
  typedef enum logic [2:0] {MG, MY, CG, CY, FL} state_t;
`else
  typedef enum logic [1:0] {MG, MY, CG, CY} state_t;
`endif

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam logic [CNT_W-1:0] MG_T       = CNT_W'(T_MG_MIN);
  localparam logic [CNT_W-1:0] MY_T       = CNT_W'(T_MY);
  localparam logic [CNT_W-1:0] CG_T       = CNT_W'(T_CG_MAX);
  localparam logic [CNT_W-1:0] CY_T       = CNT_W'(T_CY);
  localparam logic [CNT_W-1:0] MG_LAST    = CNT_W'(T_MG_MIN - 1);
  localparam logic [CNT_W-1:0] MY_LAST    = CNT_W'(T_MY - 1);
  localparam logic [CNT_W-1:0] CG_MIN_LST = CNT_W'(T_CG_MIN - 1);
  localparam logic [CNT_W-1:0] CG_LAST    = CNT_W'(T_CG_MAX - 1);
  localparam logic [CNT_W-1:0] CY_LAST    = CNT_W'(T_CY - 1);

  state_t           state;
  state_t           prev_state;
  state_t           nxt;
  logic [CNT_W-1:0] cnt;
  logic             exit_now;
  logic             car_m;
  logic             car_s;
  logic [CNT_W-1:0] remain;
  logic [31:0]      remain_w;
  logic [6:0]       remain_sat;
  logic [3:0]       tens;
  logic [3:0]       ones;
`ifdef NIGHT_MODE_EN
  logic             night_m;
  logic             night_s;
  logic             fl_on;
`endif

  always_comb begin
    exit_now = 1'b0;
    nxt      = state;
    case (state)
      MG: begin
        exit_now = (cnt >= MG_LAST) && car_s;
        nxt      = MY;
      end
      MY: begin
        exit_now = (cnt == MY_LAST);
        nxt      = CG;
      end
      CG: begin
        exit_now = (cnt == CG_LAST) || (!car_s && (cnt >= CG_MIN_LST));
        nxt      = CY;
      end
      CY: begin
        exit_now = (cnt == CY_LAST);
        nxt      = MG;
      end
`ifdef NIGHT_MODE_EN
      FL: begin
        exit_now = !night_s;
        nxt      = CY;
      end
`endif
      default: begin
        exit_now = 1'b1;
        nxt      = MG;
      end
    endcase
`ifdef NIGHT_MODE_EN
    // Night request overrides every normal exit rule.
    if (night_s && (state != FL)) begin
      exit_now = 1'b1;
      nxt      = FL;
    end
`endif
  end

  always_comb begin
    remain = '0;
    case (state)
      MG:      remain = (cnt < MG_LAST) ? (MG_T - cnt) : '0;
      MY:      remain = MY_T - cnt;
      CG:      remain = CG_T - cnt;
      CY:      remain = CY_T - cnt;
      default: remain = '0;
    endcase
    remain_w   = 32'(remain);
    remain_sat = (remain_w > 32'd99) ? 7'd99 : 7'(remain_w);
    tens       = 4'(remain_sat / 7'd10);
    ones       = 4'(remain_sat % 7'd10);
  end

  // Polarity is inherited from the existing codebase: rst_n asserts when high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= MG;
      prev_state <= MG;
      cnt        <= '0;
      car_m      <= 1'b0;
      car_s      <= 1'b0;
      m_lt       <= GRN;
      c_lt       <= RED;
      remain_bcd <= '0;
      phase_chg  <= 1'b0;
`ifdef NIGHT_MODE_EN
      night_m    <= 1'b0;
      night_s    <= 1'b0;
      fl_on      <= 1'b0;
`endif
    end else begin
      car_m <= car;
      car_s <= car_m;
`ifdef NIGHT_MODE_EN
      night_m <= night;
      night_s <= night_m;
`endif
      if (tick) begin
        if (exit_now) begin
          state <= nxt;
          cnt   <= '0;
        end else if (cnt != '1) begin
          cnt <= cnt + 1'b1;
        end
`ifdef NIGHT_MODE_EN
        if (exit_now && (nxt == FL)) fl_on <= 1'b1;
        else if (state == FL)        fl_on <= ~fl_on;
`endif
      end

      prev_state <= state;
      phase_chg  <= (state != prev_state);
      remain_bcd <= {tens, ones};

      case (state)
        MG: begin m_lt <= GRN; c_lt <= RED; end
        MY: begin m_lt <= YEL; c_lt <= RED; end
        CG: begin m_lt <= RED; c_lt <= GRN; end
        CY: begin m_lt <= RED; c_lt <= YEL; end
`ifdef NIGHT_MODE_EN
        FL: begin
          m_lt <= fl_on ? YEL : 3'b000;
          c_lt <= fl_on ? RED : 3'b000;
        end
`endif
        default: begin m_lt <= RED; c_lt <= RED; end
      endcase
    end
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized self-checking bench for traffic_light_ctrl; reference model tracks
// phase index and ticks served, and a second instance runs with T_MG_MIN=150.
module tb_traffic_light_ctrl;

  localparam int T_MG  = 25;
  localparam int T_MY  = 5;
  localparam int T_CGN = 3;
  localparam int T_CGX = 16;
  localparam int T_CY  = 5;
  localparam int T_MG2 = 150;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick  = 1'b0;
  logic       car   = 1'b0;
  logic       car2  = 1'b0;
  logic [2:0] m_lt, c_lt, m_lt2, c_lt2;
  logic [7:0] bcd, bcd2;
  logic       chg, chg2;
`ifdef NIGHT_MODE_EN
  logic       night  = 1'b0;
  logic       night2 = 1'b0;
`endif

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: phase 0..3 = MG, MY, CG, CY; el = ticks served in phase.
  int         ph, el, el2;
  logic [2:0] exp_m, exp_c;
  logic [7:0] exp_bcd, exp_bcd2;
  logic       exp_chg;

  always #5 clk = ~clk;

  traffic_light_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .car(car),
    .m_lt(m_lt), .c_lt(c_lt), .remain_bcd(bcd), .phase_chg(chg)
`ifdef NIGHT_MODE_EN
    , .night(night)
`endif
  );

  traffic_light_ctrl #(.T_MG_MIN(T_MG2)) dut2 (
    .clk(clk), .rst_n(rst_n), .tick(tick), .car(car2),
    .m_lt(m_lt2), .c_lt(c_lt2), .remain_bcd(bcd2), .phase_chg(chg2)
`ifdef NIGHT_MODE_EN
    , .night(night2)
`endif
  );

  function automatic int remain_of(int p, int e, int tmg);
    case (p)
      0:       return (e < tmg - 1) ? tmg - e : 0;
      1:       return T_MY - e;
      2:       return T_CGX - e;
      default: return T_CY - e;
    endcase
  endfunction

  function automatic logic [7:0] to_bcd(int r);
    if (r > 99) return 8'h99;
    return 8'((r / 10) * 16 + (r % 10));
  endfunction

  task automatic set_expect();
    case (ph)
      0:       begin exp_m = 3'b001; exp_c = 3'b100; end
      1:       begin exp_m = 3'b010; exp_c = 3'b100; end
      2:       begin exp_m = 3'b100; exp_c = 3'b001; end
      default: begin exp_m = 3'b100; exp_c = 3'b010; end
    endcase
    exp_bcd  = to_bcd(remain_of(ph, el, T_MG));
    exp_bcd2 = to_bcd(remain_of(0, el2, T_MG2));
  endtask

  task automatic model_reset();
    ph = 0; el = 0; el2 = 0; exp_chg = 1'b0;
    set_expect();
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) rst_n = 1'b0;
    model_reset();
  endtask

  // Drives one tick with car held stable across the synchroniser, advances the
  // model, and returns at the negedge where registered outputs reflect the tick.
  task automatic apply_tick(input logic c);
    int served;
    bit leave;
    car = c;
    repeat (2 + $urandom_range(0, 2)) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    served = el + 1;
    case (ph)
      0:       leave = c && (served >= T_MG);
      1:       leave = (served == T_MY);
      2:       leave = (served == T_CGX) || (!c && served >= T_CGN);
      default: leave = (served == T_CY);
    endcase
    exp_chg = leave;
    if (leave) begin ph = (ph + 1) % 4; el = 0; end
    else       el = (served > 255) ? 255 : served;
    el2 = (el2 + 1 > 255) ? 255 : el2 + 1;
    set_expect();
    @(negedge clk);
  endtask

  task automatic test_reset();
    car = 1'b0; rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (m_lt !== 3'b001) begin miscompares++; $display("FAIL reset m_lt: got %b want 001", m_lt); end
    vectors++; if (c_lt !== 3'b100) begin miscompares++; $display("FAIL reset c_lt: got %b want 100", c_lt); end
    vectors++; if (bcd !== 8'h00) begin miscompares++; $display("FAIL reset remain_bcd: got %h want 00", bcd); end
    vectors++; if (chg !== 1'b0) begin miscompares++; $display("FAIL reset phase_chg: got %b want 0", chg); end
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    vectors++;
    if ({m_lt, c_lt, bcd} !== {exp_m, exp_c, exp_bcd}) begin
      miscompares++;
      $display("FAIL release outputs: got %b/%b/%h want %b/%b/%h", m_lt, c_lt, bcd, exp_m, exp_c, exp_bcd);
    end
  endtask

  task automatic test_idle_main();
    for (int i = 0; i < 160; i++) begin
      apply_tick(1'b0);
      vectors++;
      if ({m_lt, c_lt, bcd, chg} !== {exp_m, exp_c, exp_bcd, exp_chg}) begin
        miscompares++;
        $display("FAIL idle tick %0d: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, m_lt, c_lt, bcd, chg, exp_m, exp_c, exp_bcd, exp_chg);
      end
      vectors++;
      if ({m_lt2, c_lt2, bcd2, chg2} !== {3'b001, 3'b100, exp_bcd2, 1'b0}) begin
        miscompares++;
        $display("FAIL sat99 tick %0d: got %b/%b/%h/%b want 001/100/%h/0",
                 i, m_lt2, c_lt2, bcd2, chg2, exp_bcd2);
      end
    end
  endtask

  task automatic test_full_cycle();
    int pulses = 0;
    pulse_reset();
    for (int i = 0; i < 102; i++) begin
      apply_tick(1'b1);
      if (chg === 1'b1) pulses++;
      vectors++;
      if ({m_lt, c_lt, bcd, chg} !== {exp_m, exp_c, exp_bcd, exp_chg}) begin
        miscompares++;
        $display("FAIL cycle tick %0d: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, m_lt, c_lt, bcd, chg, exp_m, exp_c, exp_bcd, exp_chg);
      end
    end
    vectors++;
    if (pulses !== 8) begin
      miscompares++;
      $display("FAIL cycle pulse count: got %0d want 8", pulses);
    end
  endtask

  task automatic test_cg_early();
    int cg_ticks = 0;
    for (int i = 0; i < 100 && ph != 2; i++) apply_tick(1'b1);
    apply_tick(1'b1);
    apply_tick(1'b1);
    apply_tick(1'b0);
    vectors++;
    if ({m_lt, c_lt, chg} !== {3'b100, 3'b010, 1'b1}) begin
      miscompares++;
      $display("FAIL cg early exit: got %b/%b/%b want 100/010/1", m_lt, c_lt, chg);
    end
    for (int i = 0; i < 100 && ph != 2; i++) apply_tick(1'b1);
    for (int i = 0; i < 20; i++) begin
      apply_tick(1'b0);
      cg_ticks++;
      vectors++;
      if ({m_lt, c_lt, bcd, chg} !== {exp_m, exp_c, exp_bcd, exp_chg}) begin
        miscompares++;
        $display("FAIL cg min tick %0d: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, m_lt, c_lt, bcd, chg, exp_m, exp_c, exp_bcd, exp_chg);
      end
      if (c_lt !== 3'b001) break;
    end
    vectors++;
    if (cg_ticks !== 3) begin
      miscompares++;
      $display("FAIL cg min length: got %0d ticks want 3", cg_ticks);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 200 && !(ph == 2 && el == 7); i++) apply_tick(1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if ({m_lt, c_lt, bcd, chg} !== {3'b001, 3'b100, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL mid reset: got %b/%b/%h/%b want 001/100/00/0", m_lt, c_lt, bcd, chg);
    end
    @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    model_reset();
    apply_tick(1'b1);
    vectors++;
    if ({m_lt, c_lt, bcd, chg} !== {3'b001, 3'b100, 8'h24, 1'b0}) begin
      miscompares++;
      $display("FAIL after mid reset: got %b/%b/%h/%b want 001/100/24/0", m_lt, c_lt, bcd, chg);
    end
  endtask

  task automatic test_tick_hold();
    for (int i = 0; i < 200 && !(ph == 1 && el == 2); i++) apply_tick(1'b1);
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i % 100 == 99) begin
        vectors++;
        if ({m_lt, c_lt, bcd, chg} !== {exp_m, exp_c, exp_bcd, 1'b0}) begin
          miscompares++;
          $display("FAIL hold clk %0d: got %b/%b/%h/%b want %b/%b/%h/0",
                   i, m_lt, c_lt, bcd, chg, exp_m, exp_c, exp_bcd);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      apply_tick(1'b1);
      vectors++;
      if ({m_lt, c_lt, bcd, chg} !== {exp_m, exp_c, exp_bcd, exp_chg}) begin
        miscompares++;
        $display("FAIL after hold tick %0d: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, m_lt, c_lt, bcd, chg, exp_m, exp_c, exp_bcd, exp_chg);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      apply_tick($urandom_range(0, 3) != 0);
      vectors++;
      if ({m_lt, c_lt, bcd, chg} !== {exp_m, exp_c, exp_bcd, exp_chg}) begin
        miscompares++;
        $display("FAIL random tick %0d: got %b/%b/%h/%b want %b/%b/%h/%b",
                 i, m_lt, c_lt, bcd, chg, exp_m, exp_c, exp_bcd, exp_chg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_idle_main();
    test_full_cycle();
    test_cg_early();
    test_reset_mid();
    test_tick_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
